// File: rtl/pio_in_edge_capture.sv
// pio_in_edge_capture
// Avalon-MM input port with per-bit synchroniser, sticky edge capture,
// interrupt mask and a registered level interrupt.
//
// Register map (readdata[31:WIDTH] always 0):
//   0 DATA    synchronised input value, writes ignored
//   1 DIR     reads 0, writes ignored (input-only port)
//   2 IRQMASK read/write
//   3 EDGECAP sticky capture bits, write-one-to-clear (a new edge wins over a clear)
module pio_in_edge_capture #(
    parameter int WIDTH       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_ENABLE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // The arm counter runs for SYNC_STAGES+1 clocks after reset release.
    localparam int ARM_LAST = SYNC_STAGES;
    localparam int CNT_W    = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
    logic [WIDTH-1:0]                  sync_val;
    logic [WIDTH-1:0]                  prev_val;
    logic [WIDTH-1:0]                  edge_raw;
    logic [WIDTH-1:0]                  edge_hit;
    logic [WIDTH-1:0]                  clr_bits;
    logic [WIDTH-1:0]                  wdata_w;
    logic [WIDTH-1:0]                  edge_cap;
    logic [WIDTH-1:0]                  irq_mask;
    logic [CNT_W-1:0]                  arm_count;
    logic                              armed;
    logic                              write_en;
    logic [31:0]                       read_mux;
    logic                              unused_wdata;

    assign sync_val     = sync_chain[SYNC_STAGES-1];
    assign write_en     = chipselect & ~write_n;
    assign wdata_w      = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // Shift each asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
        end
    end

    // Keep the previous synchronised value for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_val <= '0;
        end else begin
            prev_val <= sync_val;
        end
    end

    // Hold off edge detection until the zeroed chain has flushed, so inputs
    // already high at power-up do not look like rising edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_count <= '0;
            armed     <= 1'b0;
        end else if (!armed) begin
            if (arm_count == CNT_W'(ARM_LAST)) begin
                armed <= 1'b1;
            end else begin
                arm_count <= arm_count + CNT_W'(1);
            end
        end
    end

    // Pick the configured edge type and gate it with the arm flag.
    always_comb begin
        edge_raw = '0;
        if (EDGE_TYPE == 0) begin
            edge_raw = sync_val & ~prev_val;
        end else if (EDGE_TYPE == 1) begin
            edge_raw = ~sync_val & prev_val;
        end else begin
            edge_raw = sync_val ^ prev_val;
        end
        edge_hit = armed ? edge_raw : '0;
    end

    // Write-one-to-clear mask, only on a write to EDGECAP.
    always_comb begin
        clr_bits = '0;
        if (write_en && (address == 2'd3)) begin
            clr_bits = wdata_w;
        end
    end

    // Sticky capture bits; a same-cycle edge keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~clr_bits) | edge_hit;
        end
    end

    // Interrupt mask register exists only when interrupts are enabled.
    generate
        if (IRQ_ENABLE != 0) begin : g_mask
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    irq_mask <= '0;
                end else if (write_en && (address == 2'd2)) begin
                    irq_mask <= wdata_w;
                end
            end
        end else begin : g_no_mask
            assign irq_mask = '0;
        end
    endgenerate

    // Read multiplexer, zero-extended to the 32-bit bus.
    always_comb begin
        read_mux = '0;
        case (address)
            2'd0:    read_mux = 32'(sync_val);
            2'd1:    read_mux = '0;
            2'd2:    read_mux = 32'(irq_mask);
            default: read_mux = 32'(edge_cap);
        endcase
    end

    // Register read data and the level interrupt every clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= read_mux;
            irq      <= |(edge_cap & irq_mask);
        end
    end

endmodule
